// File: rtl/rsc_sseg_monitor.sv
// rtl/rsc_sseg_monitor.sv - rotating-square seven-segment bus monitor
// Rebuilds square position, direction, stall and error status from sampled anode/segment lines.
module rsc_sseg_monitor #(
  parameter int CONFIRM      = 2,
  parameter int STALL_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [6:0] sseg,
  output logic [2:0] pos,
  output logic       pos_valid,
  output logic       dir_cw,
  output logic       dir_valid,
  output logic       stalled,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam logic [3:0]  CONF       = 4'(CONFIRM);
  localparam logic [15:0] STALL_MAX  = 16'(STALL_CYCLES);
  localparam logic [6:0]  SSEG_BLANK = 7'b1111111;
  localparam logic [6:0]  SSEG_UPPER = 7'b0011100;
  localparam logic [6:0]  SSEG_LOWER = 7'b0100011;

  logic [3:0]  s1_an_q, s2_an_q;
  logic [6:0]  s1_sseg_q, s2_sseg_q;
  logic [2:0]  cand_q, cand_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  pos_q, pos_d;
  logic        pos_valid_q, pos_valid_d;
  logic        dir_cw_q, dir_cw_d;
  logic        dir_valid_q, dir_valid_d;
  logic [15:0] stall_q, stall_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        an_ok, idle, blank, upper, lower, square, illegal;
  logic [1:0]  digit;
  logic [2:0]  samp_pos;
  logic        accept, step_cw, step_ccw, jump;

  // Sample classification works only on the second synchroniser stage.
  always_comb begin
    an_ok = 1'b1;
    digit = 2'd0;
    case (s2_an_q)
      4'b1110: digit = 2'd0;
      4'b1101: digit = 2'd1;
      4'b1011: digit = 2'd2;
      4'b0111: digit = 2'd3;
      default: an_ok = 1'b0;
    endcase
    idle     = (s2_an_q == 4'b1111);
    blank    = (s2_sseg_q == SSEG_BLANK);
    upper    = (s2_sseg_q == SSEG_UPPER);
    lower    = (s2_sseg_q == SSEG_LOWER);
    square   = !idle && an_ok && (upper || lower);
    illegal  = !idle && (!an_ok || (!blank && !upper && !lower));
    samp_pos = upper ? (3'd3 - {1'b0, digit}) : (3'd4 + {1'b0, digit});
  end

  always_comb begin
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    pos_d       = pos_q;
    pos_valid_d = pos_valid_q;
    dir_cw_d    = dir_cw_q;
    dir_valid_d = dir_valid_q;
    stall_d     = stall_q;
    err_cnt_d   = err_cnt_q;

    if (square) begin
      if (samp_pos == cand_q) begin
        cnt_d = (cnt_q >= CONF) ? CONF : cnt_q + 4'd1;
      end else begin
        cand_d = samp_pos;
        cnt_d  = 4'd1;
      end
    end

    // Re-confirming the current position never counts as an accept.
    accept   = (cnt_d == CONF) && (!pos_valid_q || (cand_d != pos_q));
    step_cw  = (cand_d == pos_q + 3'd1);
    step_ccw = (cand_d == pos_q - 3'd1);
    jump     = accept && pos_valid_q && !step_cw && !step_ccw;

    if (accept) begin
      pos_d       = cand_d;
      pos_valid_d = 1'b1;
      if (pos_valid_q) begin
        if (step_cw) begin
          dir_cw_d    = 1'b1;
          dir_valid_d = 1'b1;
        end else if (step_ccw) begin
          dir_cw_d    = 1'b0;
          dir_valid_d = 1'b1;
        end else begin
          dir_valid_d = 1'b0;
        end
      end
    end

    if (accept) begin
      stall_d = 16'd0;
    end else if (pos_valid_q && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + 16'd1;
    end

    err_d = illegal || jump;
    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_an_q     <= 4'hF;
      s2_an_q     <= 4'hF;
      s1_sseg_q   <= 7'h7F;
      s2_sseg_q   <= 7'h7F;
      cand_q      <= 3'd0;
      cnt_q       <= 4'd0;
      pos_q       <= 3'd0;
      pos_valid_q <= 1'b0;
      dir_cw_q    <= 1'b0;
      dir_valid_q <= 1'b0;
      stall_q     <= 16'd0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      s1_an_q     <= an;
      s2_an_q     <= s1_an_q;
      s1_sseg_q   <= sseg;
      s2_sseg_q   <= s1_sseg_q;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      pos_valid_q <= pos_valid_d;
      dir_cw_q    <= dir_cw_d;
      dir_valid_q <= dir_valid_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign pos       = pos_q;
  assign pos_valid = pos_valid_q;
  assign dir_cw    = dir_cw_q;
  assign dir_valid = dir_valid_q;
  assign stalled   = (stall_q == STALL_MAX);
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rsc_sseg_monitor.sv
// tb/tb_rsc_sseg_monitor.sv - directed self-checking bench for rsc_sseg_monitor
module tb_rsc_sseg_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] an;
  logic [6:0] sseg;
  logic [2:0] pos;
  logic       pos_valid, dir_cw, dir_valid, stalled, err;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  rsc_sseg_monitor #(.CONFIRM(2), .STALL_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .an        (an),
    .sseg      (sseg),
    .pos       (pos),
    .pos_valid (pos_valid),
    .dir_cw    (dir_cw),
    .dir_valid (dir_valid),
    .stalled   (stalled),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Position p: 0-3 upper square on digit 3-p, 4-7 lower square on digit p-4.
  task automatic drive_pos(input int p);
    int d;
    logic [3:0] onehot;
    d      = (p < 4) ? (3 - p) : (p - 4);
    onehot = 4'b0001 << d;
    an     = ~onehot;
    sseg   = (p < 4) ? 7'b0011100 : 7'b0100011;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    an    = 4'b0111;
    sseg  = 7'b0011100;
    #2;
    tick(2);
    total++;
    if ({pos, pos_valid, dir_cw, dir_valid, stalled, err, err_cnt} !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", {pos, pos_valid, dir_cw, dir_valid, stalled, err, err_cnt});
    end
    reset = 1'b0;
    tick(3);
    total++;
    if (pos_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_early_valid: got %0b want 0", pos_valid);
    end
    tick(1);
    total++;
    if ({pos_valid, pos, dir_valid} !== {1'b1, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_first_accept: valid=%0b pos=%0d dv=%0b want 1 0 0", pos_valid, pos, dir_valid);
    end
  endtask

  task automatic test_clockwise;
    for (int i = 1; i <= 8; i++) begin
      drive_pos(i % 8);
      tick(8);
      total++;
      if ({pos, dir_cw, dir_valid} !== {3'(i % 8), 1'b1, 1'b1}) begin
        bad++;
        $display("FAIL cw_step%0d: pos=%0d cw=%0b dv=%0b want %0d 1 1", i, pos, dir_cw, dir_valid, i % 8);
      end
    end
    total++;
    if (err_cnt !== 8'd0) begin
      bad++;
      $display("FAIL cw_err_cnt: got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_reversal;
    for (int p = 1; p <= 5; p++) begin
      drive_pos(p);
      tick(8);
    end
    drive_pos(4);
    tick(8);
    total++;
    if ({pos, dir_cw, dir_valid, err_cnt} !== {3'd4, 1'b0, 1'b1, 8'd0}) begin
      bad++;
      $display("FAIL reversal: pos=%0d cw=%0b dv=%0b errs=%0d want 4 0 1 0", pos, dir_cw, dir_valid, err_cnt);
    end
  endtask

  task automatic test_halt;
    drive_pos(3);
    tick(8);
    drive_pos(2);
    tick(4);
    total++;
    if (pos !== 3'd2) begin
      bad++;
      $display("FAIL halt_accept: pos=%0d want 2", pos);
    end
    tick(15);
    total++;
    if (stalled !== 1'b0) begin
      bad++;
      $display("FAIL halt_early: stalled=%0b want 0", stalled);
    end
    tick(1);
    total++;
    if (stalled !== 1'b1) begin
      bad++;
      $display("FAIL halt_at16: stalled=%0b want 1", stalled);
    end
    tick(4);
    drive_pos(3);
    tick(3);
    total++;
    if ({stalled, pos} !== {1'b1, 3'd2}) begin
      bad++;
      $display("FAIL halt_hold: stalled=%0b pos=%0d want 1 2", stalled, pos);
    end
    tick(1);
    total++;
    if ({stalled, pos, dir_cw} !== {1'b0, 3'd3, 1'b1}) begin
      bad++;
      $display("FAIL halt_release: stalled=%0b pos=%0d cw=%0b want 0 3 1", stalled, pos, dir_cw);
    end
  endtask

  task automatic test_illegal;
    tick(4);
    an   = 4'b0011;
    sseg = 7'b0011100;
    tick(1);
    drive_pos(3);
    sseg = 7'b0000000;
    tick(1);
    drive_pos(3);
    tick(1);
    total++;
    if ({err, err_cnt} !== {1'b1, 8'd1}) begin
      bad++;
      $display("FAIL illegal_first: err=%0b cnt=%0d want 1 1", err, err_cnt);
    end
    tick(1);
    total++;
    if ({err, err_cnt} !== {1'b1, 8'd2}) begin
      bad++;
      $display("FAIL illegal_second: err=%0b cnt=%0d want 1 2", err, err_cnt);
    end
    tick(1);
    total++;
    if ({err, err_cnt, pos} !== {1'b0, 8'd2, 3'd3}) begin
      bad++;
      $display("FAIL illegal_after: err=%0b cnt=%0d pos=%0d want 0 2 3", err, err_cnt, pos);
    end
    drive_pos(6);
    tick(1);
    drive_pos(3);
    tick(8);
    total++;
    if ({pos, err_cnt, dir_cw, dir_valid} !== {3'd3, 8'd2, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL glitch: pos=%0d cnt=%0d cw=%0b dv=%0b want 3 2 1 1", pos, err_cnt, dir_cw, dir_valid);
    end
  endtask

  task automatic test_jump;
    drive_pos(2);
    tick(8);
    drive_pos(1);
    tick(8);
    drive_pos(5);
    tick(3);
    total++;
    if ({err, pos} !== {1'b0, 3'd1}) begin
      bad++;
      $display("FAIL jump_pre: err=%0b pos=%0d want 0 1", err, pos);
    end
    tick(1);
    total++;
    if ({pos, dir_valid, err, err_cnt} !== {3'd5, 1'b0, 1'b1, 8'd3}) begin
      bad++;
      $display("FAIL jump_accept: pos=%0d dv=%0b err=%0b cnt=%0d want 5 0 1 3", pos, dir_valid, err, err_cnt);
    end
    tick(1);
    total++;
    if ({err, err_cnt} !== {1'b0, 8'd3}) begin
      bad++;
      $display("FAIL jump_pulse: err=%0b cnt=%0d want 0 3", err, err_cnt);
    end
  endtask

  task automatic test_reset_mid;
    drive_pos(6);
    tick(3);
    reset = 1'b1;
    #1;
    total++;
    if ({pos, pos_valid, dir_valid, err, err_cnt} !== 14'd0) begin
      bad++;
      $display("FAIL midreset_async: pos=%0d valid=%0b cnt=%0d want 0 0 0", pos, pos_valid, err_cnt);
    end
    tick(1);
    reset = 1'b0;
    tick(3);
    total++;
    if (pos_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_early: valid=%0b want 0", pos_valid);
    end
    tick(1);
    total++;
    if ({pos, pos_valid, dir_valid, err, err_cnt} !== {3'd6, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL midreset_first: pos=%0d valid=%0b dv=%0b err=%0b cnt=%0d want 6 1 0 0 0",
               pos, pos_valid, dir_valid, err, err_cnt);
    end
  endtask

  // Square samples interleaved with blank digits, as seen on a multiplexed bus.
  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        drive_pos(7);
      end else begin
        an   = 4'b1110;
        sseg = 7'b1111111;
      end
      tick(1);
      if (i == 3) begin
        total++;
        if (pos !== 3'd6) begin
          bad++;
          $display("FAIL mux_early: pos=%0d want 6", pos);
        end
      end
      if (i == 4) begin
        total++;
        if ({pos, dir_cw, dir_valid, err_cnt} !== {3'd7, 1'b1, 1'b1, 8'd0}) begin
          bad++;
          $display("FAIL mux_accept: pos=%0d cw=%0b dv=%0b cnt=%0d want 7 1 1 0", pos, dir_cw, dir_valid, err_cnt);
        end
      end
    end
  endtask

  task automatic test_saturation;
    an   = 4'b0011;
    sseg = 7'b0011100;
    tick(262);
    total++;
    if ({err, err_cnt} !== {1'b1, 8'd255}) begin
      bad++;
      $display("FAIL err_saturate: err=%0b cnt=%0d want 1 255", err, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_clockwise();
    test_reversal();
    test_halt();
    test_illegal();
    test_jump();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
